// File: rtl/simt_mem_pkg.sv
// Shared types and sizes for the SIMT lane-to-bank data SRAM arbiter.
package simt_mem_pkg;
  localparam int NUM_LANES = 4;
  localparam int NUM_BANKS = 4;
  localparam int AW        = 14;
  localparam int DW        = 32;
  localparam int BW        = $clog2(NUM_BANKS);
  localparam int RW        = AW - BW;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} arb_state_t;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
  } lane_req_t;

  // Word addresses are interleaved across banks on their low bits.
  function automatic logic [BW-1:0] bank_of(input logic [AW-1:0] addr);
    return addr[BW-1:0];
  endfunction
endpackage

// File: rtl/sram_bank_arbiter_bank_pick.sv
// Per-bank priority picker: one-hot grant to the highest-index pending lane mapped to BANK.
module bank_pick
  import simt_mem_pkg::*;
#(
  parameter int BANK = 0
) (
  input  logic [NUM_LANES-1:0]    pending,
  input  logic [NUM_LANES*BW-1:0] lane_bank,
  output logic [NUM_LANES-1:0]    grant
);
  always_comb begin
    grant = '0;
    // Ascending scan so a later (higher-index) match overrides earlier ones.
    for (int l = 0; l < NUM_LANES; l++) begin
      if (pending[l] && (lane_bank[l*BW +: BW] == BW'(BANK))) begin
        grant    = '0;
        grant[l] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/sram_bank_arbiter.sv
// Serializes a 4-lane SIMT memory batch onto a 4-bank single-port SRAM and returns per-lane read data.
// Optional macro SRAM_ARB_PERF_EN adds the saturating perf_conflict_cycles counter output.
module sram_bank_arbiter
  import simt_mem_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [NUM_LANES-1:0]    req_lane,
  input  logic [NUM_LANES-1:0]    req_we,
  input  logic [NUM_LANES*AW-1:0] req_addr,
  input  logic [NUM_LANES*DW-1:0] req_wd,
  output logic                    rsp_valid,
  output logic [NUM_LANES*DW-1:0] rsp_rd,
  output logic [NUM_BANKS-1:0]    bank_en,
  output logic [NUM_BANKS-1:0]    bank_we,
  output logic [NUM_BANKS*RW-1:0] bank_row,
  output logic [NUM_BANKS*DW-1:0] bank_wd,
  input  logic [NUM_BANKS*DW-1:0] bank_rd
`ifdef SRAM_ARB_PERF_EN
  ,
  output logic [31:0]             perf_conflict_cycles
`endif
);
  arb_state_t                              state, state_nxt;
  lane_req_t [NUM_LANES-1:0]               req_p0;
  logic [NUM_LANES-1:0]                    pending, pending_nxt, granted, lane_we;
  logic [NUM_LANES*BW-1:0]                 lane_bank;
  logic [NUM_BANKS-1:0][NUM_LANES-1:0]     grant;
  logic [NUM_BANKS-1:0][NUM_LANES-1:0]     gnt_p1;
  logic                                    accept;

  assign accept    = req_valid && (state == IDLE);
  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == DONE);

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    assign lane_bank[l*BW +: BW] = bank_of(req_p0[l].addr);
    assign lane_we[l]            = req_p0[l].we;
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    bank_pick #(.BANK(b)) u_pick (
      .pending   (pending),
      .lane_bank (lane_bank),
      .grant     (grant[b])
    );
  end

  always_comb begin
    granted = '0;
    for (int b = 0; b < NUM_BANKS; b++) granted = granted | grant[b];
    pending_nxt = pending & ~granted;
  end

  always_comb begin
    bank_en  = '0;
    bank_we  = '0;
    bank_row = '0;
    bank_wd  = '0;
    if (state == ISSUE) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        for (int l = 0; l < NUM_LANES; l++) begin
          if (grant[b][l]) begin
            bank_en[b]             = 1'b1;
            bank_we[b]             = req_p0[l].we;
            bank_row[b*RW +: RW]   = req_p0[l].addr[AW-1:BW];
            bank_wd[b*DW +: DW]    = req_p0[l].wd;
          end
        end
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid) state_nxt = (req_lane == '0) ? DONE : ISSUE;
      ISSUE:   if (pending_nxt == '0) state_nxt = DRAIN;
      DRAIN:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p0: batch capture at accept; no reset on the data path.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int l = 0; l < NUM_LANES; l++) begin
        req_p0[l].we   <= req_we[l];
        req_p0[l].addr <= req_addr[l*AW +: AW];
        req_p0[l].wd   <= req_wd[l*DW +: DW];
      end
    end
  end

  // Stage p1: read grants of the current round, consumed one edge later when bank_rd is valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      pending <= '0;
      gnt_p1  <= '0;
      rsp_rd  <= '0;
    end else begin
      state <= state_nxt;
      if (accept) pending <= req_lane;
      else if (state == ISSUE) pending <= pending_nxt;
      for (int b = 0; b < NUM_BANKS; b++) begin
        gnt_p1[b] <= (state == ISSUE) ? (grant[b] & ~lane_we) : '0;
        for (int l = 0; l < NUM_LANES; l++) begin
          if (gnt_p1[b][l]) rsp_rd[l*DW +: DW] <= bank_rd[b*DW +: DW];
        end
      end
    end
  end

`ifdef SRAM_ARB_PERF_EN
  logic first_issue;

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_conflict_cycles <= '0;
      first_issue          <= 1'b0;
    end else begin
      if (accept) first_issue <= 1'b1;
      else if (state == ISSUE) first_issue <= 1'b0;
      if ((state == ISSUE) && !first_issue && (perf_conflict_cycles != '1))
        perf_conflict_cycles <= perf_conflict_cycles + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_sram_bank_arbiter.sv
// Directed bench for sram_bank_arbiter with a behavioural banked SRAM and a response scoreboard.
module tb_sram_bank_arbiter;
  import simt_mem_pkg::*;

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    req_valid;
  logic                    req_ready;
  logic [NUM_LANES-1:0]    req_lane;
  logic [NUM_LANES-1:0]    req_we;
  logic [NUM_LANES*AW-1:0] req_addr;
  logic [NUM_LANES*DW-1:0] req_wd;
  logic                    rsp_valid;
  logic [NUM_LANES*DW-1:0] rsp_rd;
  logic [NUM_BANKS-1:0]    bank_en;
  logic [NUM_BANKS-1:0]    bank_we;
  logic [NUM_BANKS*RW-1:0] bank_row;
  logic [NUM_BANKS*DW-1:0] bank_wd;
  logic [NUM_BANKS*DW-1:0] bank_rd;
`ifdef SRAM_ARB_PERF_EN
  logic [31:0]             perf_conflict_cycles;
`endif

  sram_bank_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_lane  (req_lane),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wd    (req_wd),
    .rsp_valid (rsp_valid),
    .rsp_rd    (rsp_rd),
    .bank_en   (bank_en),
    .bank_we   (bank_we),
    .bank_row  (bank_row),
    .bank_wd   (bank_wd),
    .bank_rd   (bank_rd)
`ifdef SRAM_ARB_PERF_EN
    ,
    .perf_conflict_cycles (perf_conflict_cycles)
`endif
  );

  always #5 clk = ~clk;

  // Single-port synchronous-read banks.
  logic [DW-1:0] mem [NUM_BANKS][1 << RW];
  always @(posedge clk) begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (bank_en[b]) begin
        if (bank_we[b]) mem[b][bank_row[b*RW +: RW]] <= bank_wd[b*DW +: DW];
        else bank_rd[b*DW +: DW] <= mem[b][bank_row[b*RW +: RW]];
      end
    end
  end

  typedef struct {
    logic [NUM_LANES*DW-1:0] rd;
    int                      lat;
  } exp_t;

  exp_t                    sb[$];
  logic [DW-1:0]           ref_mem [1 << AW];
  logic [NUM_LANES*DW-1:0] exp_rsp;
  int                      checks = 0;
  int                      errors = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Sequential reference: lanes in descending index order equals per-bank round order.
  task automatic batch(input logic [3:0] lane, input logic [3:0] we,
                       input logic [AW-1:0] a0, a1, a2, a3,
                       input logic [DW-1:0] d0, d1, d2, d3);
    logic [AW-1:0] a [NUM_LANES];
    logic [DW-1:0] d [NUM_LANES];
    int            cnt [NUM_BANKS];
    int            r, n;
    logic          seen_en;
    exp_t          e;
    a[0] = a0; a[1] = a1; a[2] = a2; a[3] = a3;
    d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
    for (int b = 0; b < NUM_BANKS; b++) cnt[b] = 0;
    for (int l = NUM_LANES - 1; l >= 0; l--) begin
      if (lane[l]) begin
        if (we[l]) ref_mem[a[l]] = d[l];
        else exp_rsp[l*DW +: DW] = ref_mem[a[l]];
        cnt[a[l] % NUM_BANKS]++;
      end
    end
    r = 0;
    for (int b = 0; b < NUM_BANKS; b++) if (cnt[b] > r) r = cnt[b];
    e.rd  = exp_rsp;
    e.lat = (r == 0) ? 1 : r + 2;
    sb.push_back(e);

    check("ready_before", req_ready, 1'b1);
    req_lane  = lane;
    req_we    = we;
    req_addr  = {a3, a2, a1, a0};
    req_wd    = {d3, d2, d1, d0};
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    req_lane  = 4'($urandom);
    req_we    = 4'($urandom);
    req_addr  = {$urandom, $urandom};
    req_wd    = {$urandom, $urandom, $urandom, $urandom};
    n = 0;
    seen_en = 1'b0;
    while (!rsp_valid && n < 40) begin
      check("ready_busy", req_ready, 1'b0);
      seen_en = seen_en | (|bank_en);
      step();
      n++;
    end
    seen_en = seen_en | (|bank_en);
    check("ready_at_rsp", req_ready, 1'b0);
    e = sb.pop_front();
    check("latency", 128'(n + 1), 128'(e.lat));
    check("rsp_rd", rsp_rd, e.rd);
    check("bank_en_used", seen_en, (lane != 4'b0));
    step();
    check("rsp_pulse_end", rsp_valid, 1'b0);
    check("ready_after", req_ready, 1'b1);
  endtask

  initial begin
    logic seen;
    reset     = 1'b1;
    req_valid = 1'b0;
    req_lane  = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wd    = '0;
    exp_rsp   = '0;
    repeat (3) step();
    reset = 1'b0;
    check("rst_ready", req_ready, 1'b1);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_rd", rsp_rd, '0);
    check("rst_bank_en", {bank_en, bank_we}, '0);

    // No-conflict writes then reads.
    batch(4'b1111, 4'b1111, 14'd0, 14'd5, 14'd3, 14'd2, 32'd123, 32'd456, 32'd789, 32'd5555);
    batch(4'b1111, 4'b0000, 14'd5, 14'd2, 14'd3, 14'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    check("nc_lane0", rsp_rd[31:0], 32'd456);
    check("nc_lane1", rsp_rd[63:32], 32'd5555);

    // Full conflict: pre-write then read, all on bank 0.
    batch(4'b1111, 4'b1111, 14'd12, 14'd8, 14'd4, 14'd0, 32'd5555, 32'd789, 32'd456, 32'd123);
    batch(4'b1111, 4'b0000, 14'd12, 14'd8, 14'd4, 14'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    check("fc_lane3", rsp_rd[127:96], 32'd123);

    // Same-word writes: lane 0 is granted last so its data persists.
    batch(4'b1111, 4'b1111, 14'd0, 14'd0, 14'd0, 14'd0, 32'd10, 32'd20, 32'd30, 32'd40);
    check("same_word_mem", mem[0][0], 32'd10);

    // Partial mask on bank 1: lane 2 writes addr 9, lane 0 reads it in the next round.
    batch(4'b0101, 4'b0100, 14'd9, 14'd1, 14'd9, 14'd7, 32'd0, 32'd0, 32'd77, 32'd0);
    check("pm_lane0", rsp_rd[31:0], 32'd77);

    // Empty batch.
    batch(4'b0000, 4'b0000, 14'd0, 14'd0, 14'd0, 14'd0, 32'd0, 32'd0, 32'd0, 32'd0);

    // Reset during the second ISSUE cycle of a conflict batch.
    req_lane  = 4'b1111;
    req_we    = 4'b0000;
    req_addr  = {14'd0, 14'd4, 14'd8, 14'd12};
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    step();
    check("mid_bank_en_active", |bank_en, 1'b1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    exp_rsp = '0;
    check("mid_bank_en", bank_en, '0);
    check("mid_ready", req_ready, 1'b1);
    check("mid_rsp_valid", rsp_valid, 1'b0);
    check("mid_rsp_rd", rsp_rd, '0);
    seen = 1'b0;
    repeat (10) begin
      seen = seen | rsp_valid | (|bank_en);
      step();
    end
    check("mid_quiet", seen, 1'b0);

    // Conflict batch followed by a conflict-free batch.
    batch(4'b1111, 4'b0000, 14'd12, 14'd8, 14'd4, 14'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    batch(4'b1111, 4'b0000, 14'd5, 14'd2, 14'd3, 14'd0, 32'd0, 32'd0, 32'd0, 32'd0);
`ifdef SRAM_ARB_PERF_EN
    check("perf_conflict", perf_conflict_cycles, 32'd3);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
